// File: rtl/mips_trace_pkg.sv
// Shared types and entry layout for the MIPS retire-trace buffer.
package mips_trace_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned WBREG_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } trace_state_e;

    // Entry layout, LSB first: wb_data, wb_reg, wb_en, instr, pc.
    function automatic int unsigned wbreg_lsb(input int unsigned xlen);
        return xlen;
    endfunction

    function automatic int unsigned wben_bit(input int unsigned xlen);
        return xlen + WBREG_W;
    endfunction

    function automatic int unsigned instr_lsb(input int unsigned xlen);
        return xlen + WBREG_W + 1;
    endfunction

    function automatic int unsigned pc_lsb(input int unsigned xlen);
        return xlen + WBREG_W + 1 + INSTR_W;
    endfunction

    function automatic int unsigned entry_w(input int unsigned xlen);
        return 2 * xlen + INSTR_W + WBREG_W + 1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array with one synchronous write and one combinational read port.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 102
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_trace_buffer.sv
// Retire-trace capture unit: circular capture, post-trigger stop, oldest-first readout.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input  logic                     Globalclk,
    input  logic                     Globalreset,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [31:0]              ret_instr,
    input  logic                     ret_wb_en,
    input  logic [4:0]               ret_wb_reg,
    input  logic [XLEN-1:0]          ret_wb_data,
    input  logic                     arm,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     force_trig,
    input  logic                     rd_start,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [2*XLEN+37:0]       rd_data,
    output logic                     rd_last,
    output logic                     busy,
    output logic                     done,
    output logic                     wrapped,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_w(XLEN);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] post_q, post_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] remain_q, remain_d;
    logic          wrapped_q, wrapped_d;

    logic          we;
    logic          capture;
    logic          hit;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;

    assign wdata = {ret_pc, ret_instr, ret_wb_en, ret_wb_reg, ret_wb_data};

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk_i   (Globalclk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge Globalclk) begin
        if (Globalreset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            post_q    <= '0;
            count_q   <= '0;
            remain_q  <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            post_q    <= post_d;
            count_q   <= count_d;
            remain_q  <= remain_d;
            wrapped_q <= wrapped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        post_d    = post_q;
        count_d   = count_q;
        remain_d  = remain_q;
        wrapped_d = wrapped_q;
        we        = 1'b0;

        capture = ret_valid && ((state_q == ST_ARMED) || (state_q == ST_POST));
        hit     = (ret_valid && trig_en && (ret_pc == trig_pc)) || force_trig;

        // Shared capture path for ARMED and POST; count saturates once the ring is full.
        if (capture) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_q == CW'(DEPTH)) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    wr_ptr_d  = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (hit) begin
                    if (POST_TRIG == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_POST;
                        post_d  = AW'(POST_TRIG);
                    end
                end
            end
            ST_POST: begin
                if (capture) begin
                    post_d = post_q - AW'(1);
                    if (post_q == AW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d   = ST_ARMED;
                    wr_ptr_d  = '0;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                end else if (rd_start && (count_q != '0)) begin
                    // After a wrap the oldest entry sits at the write pointer.
                    state_d  = ST_READ;
                    rd_ptr_d = wrapped_q ? wr_ptr_q : '0;
                    remain_d = count_q;
                end
            end
            ST_READ: begin
                if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    remain_d = remain_q - CW'(1);
                    if (remain_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_valid = (state_q == ST_READ);
    assign rd_last  = (state_q == ST_READ) && (remain_q == CW'(1));
    assign rd_data  = (state_q == ST_READ) ? rdata : '0;
    assign busy     = (state_q == ST_ARMED) || (state_q == ST_POST);
    assign done     = (state_q == ST_DONE);
    assign wrapped  = wrapped_q;
    assign count    = count_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer; two instances share stimulus (POST_TRIG=0 and 4).
module tb_mips_trace_buffer;

    localparam int unsigned XLEN = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned EW = 2 * XLEN + 38;

    logic            clk;
    logic            Globalreset;
    logic            ret_valid;
    logic [31:0]     ret_pc;
    logic [31:0]     ret_instr;
    logic            ret_wb_en;
    logic [4:0]      ret_wb_reg;
    logic [31:0]     ret_wb_data;
    logic            arm;
    logic            trig_en;
    logic [31:0]     trig_pc;
    logic            force_trig;
    logic            rd_start;
    logic            rd_ready;

    logic            rd_valid_a, rd_last_a, busy_a, done_a, wrapped_a;
    logic [EW-1:0]   rd_data_a;
    logic [4:0]      count_a;
    logic            rd_valid_b, rd_last_b, busy_b, done_b, wrapped_b;
    logic [EW-1:0]   rd_data_b;
    logic [4:0]      count_b;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] bp_pat = 4'b1001;

    mips_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(0)) u_dut_a (
        .Globalclk(clk), .Globalreset(Globalreset), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_instr(ret_instr), .ret_wb_en(ret_wb_en), .ret_wb_reg(ret_wb_reg),
        .ret_wb_data(ret_wb_data), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_last(rd_last_a), .busy(busy_a),
        .done(done_a), .wrapped(wrapped_a), .count(count_a)
    );

    mips_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(4)) u_dut_b (
        .Globalclk(clk), .Globalreset(Globalreset), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_instr(ret_instr), .ret_wb_en(ret_wb_en), .ret_wb_reg(ret_wb_reg),
        .ret_wb_data(ret_wb_data), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_last(rd_last_b), .busy(busy_b),
        .done(done_b), .wrapped(wrapped_b), .count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] ent(input logic [31:0] pc);
        logic [31:0] instr;
        instr = pc ^ 32'hDEAD_0000;
        return {pc, instr, pc[2], pc[6:2], ~pc};
    endfunction

    task automatic retire(input logic [31:0] pc, input logic ft);
        ret_valid   = 1'b1;
        ret_pc      = pc;
        ret_instr   = pc ^ 32'hDEAD_0000;
        ret_wb_en   = pc[2];
        ret_wb_reg  = pc[6:2];
        ret_wb_data = ~pc;
        force_trig  = ft;
        tick();
        ret_valid   = 1'b0;
        force_trig  = 1'b0;
    endtask

    task automatic chk_zero_b(input string tag);
        chk(tag, 128'({rd_valid_b, rd_last_b, busy_b, done_b, wrapped_b, count_b, rd_data_b}), 128'd0);
    endtask

    // Oldest-first readout of instance b; bp applies the 1,0,0,1 ready pattern.
    task automatic read_b(input int n, input logic [31:0] first_pc, input logic bp);
        int idx = 0;
        int cyc = 0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (idx < n && cyc < 200) begin
            chk("rd_valid", 128'(rd_valid_b), 128'd1);
            chk("rd_data", 128'(rd_data_b), 128'(ent(first_pc + 32'(4 * idx))));
            chk("rd_last", 128'(rd_last_b), 128'(idx == n - 1));
            rd_ready = bp ? bp_pat[cyc % 4] : 1'b1;
            tick();
            if (rd_ready) idx++;
            cyc++;
        end
        rd_ready = 1'b0;
        chk("read_count", 128'(idx), 128'(n));
        chk("read_end", 128'({done_b, rd_valid_b, rd_last_b}), 128'(3'b100));
    endtask

    initial begin
        Globalreset = 1'b1; ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_wb_en = 1'b0;
        ret_wb_reg = '0; ret_wb_data = '0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
        force_trig = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
        tick();
        tick();
        chk_zero_b("reset_b");
        chk("reset_a", 128'({rd_valid_a, rd_last_a, busy_a, done_a, wrapped_a, count_a, rd_data_a}), 128'd0);
        Globalreset = 1'b0;

        // Forced trigger on the third retire with POST_TRIG=0
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("armed_a", 128'({busy_a, done_a, count_a}), 128'({1'b1, 1'b0, 5'd0}));
        retire(32'h0, 1'b0);
        retire(32'h4, 1'b0);
        retire(32'h8, 1'b1);
        chk("t1_status_a", 128'({busy_a, done_a, wrapped_a, count_a}), 128'({1'b0, 1'b1, 1'b0, 5'd3}));
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_rd_a", 128'({rd_valid_a, rd_last_a, rd_data_a}),
                128'({1'b1, 1'(i == 2), ent(32'(4 * i))}));
            tick();
        end
        rd_ready = 1'b0;
        chk("t1_end_a", 128'({done_a, rd_valid_a, rd_data_a}), 128'({1'b1, 1'b0, 102'd0}));

        // Arm in DONE together with a retire: that retire is not captured
        arm = 1'b1;
        retire(32'h200, 1'b0);
        arm = 1'b0;
        chk("arm_retire_a", 128'({busy_a, done_a, wrapped_a, count_a}), 128'({1'b1, 1'b0, 1'b0, 5'd0}));

        // Matching PC with trig_en=0 must not trigger
        trig_pc = 32'h10;
        trig_en = 1'b0;
        retire(32'h10, 1'b0);
        chk("no_trig_a", 128'({busy_a, done_a, count_a}), 128'({1'b1, 1'b0, 5'd1}));

        // force_trig without ret_valid triggers but captures nothing
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        chk("force_only_a", 128'({busy_a, done_a, count_a}), 128'({1'b0, 1'b1, 5'd1}));

        // Instance b is mid-POST (5 captured, triggers ignored); reset it there
        chk("post_b", 128'({busy_b, done_b, count_b}), 128'({1'b1, 1'b0, 5'd5}));
        Globalreset = 1'b1;
        tick();
        chk_zero_b("reset_post_b");
        Globalreset = 1'b0;

        // PC-match trigger at 100 with POST_TRIG=4 after the ring wraps
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig_en = 1'b1;
        trig_pc = 32'd100;
        for (int i = 0; i < 40; i++) begin
            retire(32'(4 * i), 1'b0);
        end
        chk("t2_status_b", 128'({busy_b, done_b, wrapped_b, count_b}), 128'({1'b0, 1'b1, 1'b1, 5'd16}));
        read_b(16, 32'd56, 1'b1);
        read_b(16, 32'd56, 1'b0);

        // Reset in the middle of a readout
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_ready = 1'b1;
        tick();
        tick();
        chk("mid_read_b", 128'({rd_valid_b, rd_data_b}), 128'({1'b1, ent(32'd64)}));
        rd_ready = 1'b0;
        Globalreset = 1'b1;
        tick();
        chk_zero_b("reset_read_b");
        Globalreset = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_b", 128'({busy_b, done_b, count_b}), 128'({1'b1, 1'b0, 5'd0}));

        // ret_valid gaps: only real retires consume post-count entries
        trig_pc = 32'h20;
        retire(32'h20, 1'b0);
        tick();
        retire(32'h24, 1'b0);
        tick();
        retire(32'h28, 1'b0);
        retire(32'h2c, 1'b0);
        tick();
        chk("gap_post_b", 128'({busy_b, done_b, count_b}), 128'({1'b1, 1'b0, 5'd4}));
        retire(32'h30, 1'b0);
        chk("gap_done_b", 128'({busy_b, done_b, wrapped_b, count_b}), 128'({1'b0, 1'b1, 1'b0, 5'd5}));
        read_b(5, 32'h20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
